// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - start/operand/result bundle for the bit-serial adder sequencer
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             ser_shift;
  logic             ser_bit;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done;

  modport master (
    output start, a_in, b_in,
    input  busy, ser_shift, ser_bit, sum, cout, done
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, ser_shift, ser_bit, sum, cout, done
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer, LSB-first through one full-adder slice
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, acc, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    count;
  logic             s, carry_next, last, accept;
  logic             busy_c, ser_shift_c, done_c;

  assign s          = a_reg[0] ^ b_reg[0] ^ carry;
  assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry) | (b_reg[0] & carry);
  assign last       = (count == CW'(WIDTH - 1));
  // DONE accepts a new start just like IDLE, giving back-to-back operation
  assign accept     = (state != SHIFT) && bus.start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy_c      = 1'b0;
    ser_shift_c = 1'b0;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = SHIFT;
      end
      SHIFT: begin
        busy_c      = 1'b1;
        ser_shift_c = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = bus.start ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_reg <= bus.a_in;
      b_reg <= bus.b_in;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else if (state == SHIFT) begin
      carry <= carry_next;
      a_reg <= {1'b0, a_reg[WIDTH-1:1]};
      b_reg <= {1'b0, b_reg[WIDTH-1:1]};
      acc   <= {s, acc[WIDTH-1:1]};
      count <= count + 1'b1;
      if (last) begin
        sum_q  <= {s, acc[WIDTH-1:1]};
        cout_q <= carry_next;
      end
    end
  end

  assign bus.busy      = busy_c;
  assign bus.ser_shift = ser_shift_c;
  assign bus.done      = done_c;
  assign bus.ser_bit   = s;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer for the bit-serial adder datapath.
- Accepts two parallel WIDTH-bit operands on a start pulse, shifts them LSB-first through a single full-adder slice with a carry flip-flop, and assembles the sum.
- Emits a per-bit shift strobe and sum bit so a downstream serial-in/parallel-out register can run in lockstep.
- Presents the parallel sum and carry-out with a one-cycle done pulse.

Parameters:
WIDTH, 4, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request an addition; sampled only when busy=0
a_in  input  WIDTH  operand A, captured on the accepted start edge
b_in  input  WIDTH  operand B, captured on the accepted start edge
busy  output  1  high while in SHIFT state
ser_shift  output  1  high during each SHIFT cycle; shift strobe for the downstream SIPO
ser_bit  output  1  current sum bit, valid when ser_shift=1; equals a_reg[0]^b_reg[0]^carry
sum  output  WIDTH  parallel result, updated only on entry to DONE, then held
cout  output  1  final carry, updated only on entry to DONE, then held
done  output  1  one-cycle pulse, high in DONE state

Behaviour:
- Registered state machine with states IDLE, SHIFT and DONE. The counter is clog2(WIDTH+1) bits wide.
- Reset (any state, including mid-operation):
  - State goes to IDLE.
  - Operand registers, sum shift register, carry, counter, sum and cout all go to 0.
  - busy, done and ser_shift go to 0.
  - Reset has priority over start.
- IDLE:
  - If start=1 at an edge: load a_reg=a_in, b_reg=b_in, carry=0, count=0, acc=0; go to SHIFT.
  - Otherwise hold.
- SHIFT, one bit per cycle, with s = a_reg[0]^b_reg[0]^carry:
  - carry <= majority(a_reg[0], b_reg[0], carry)
  - a_reg, b_reg shift right by 1, zero-filled
  - acc shifts right with s inserted at the MSB
  - count <= count+1
  - At the edge where count==WIDTH-1: go to DONE, sum <= the shifted acc value (s at the MSB), cout <= the new carry.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1, it is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
  - sum and cout hold until the next DONE entry or reset.
- Latency: start accepted at edge E. The SHIFT cycles fall between edges E+1..E+WIDTH. done is high in the cycle following edge E+WIDTH. Throughput is one addition per WIDTH+1 cycles.
- ser_shift=1 for exactly WIDTH consecutive cycles per operation. ser_bit presents sum bits LSB first.
- start while busy=1 is ignored: no operand recapture and no effect on the operation in progress.
- Operand inputs are sampled only on the accepted start edge. Changes on a_in/b_in during SHIFT have no effect.
- Arithmetic is unsigned modulo 2^WIDTH, with cout carrying the overflow bit.
- No X may propagate: all registers are reset.

Test Plan:
1. Reset, then start with a=5, b=3 (WIDTH=4) → ser_bit sequence 0,0,0,1 across 4 ser_shift cycles; done pulses 5 cycles after the start edge; sum=8, cout=0.
2. a=15, b=1 → sum=0, cout=1. Then a=9, b=9 → sum=2, cout=1. sum/cout must hold their values after done falls.
3. Start for 5+3, then pulse start with a=1, b=1 on the 2nd SHIFT cycle → ignored; result is still sum=8, cout=0; busy stays high for exactly 4 cycles.
4. Assert reset on the 3rd SHIFT cycle → next cycle busy=0, ser_shift=0, sum=0, cout=0, no done pulse. A subsequent 7+7 gives sum=14, cout=0.
5. Hold start=1 continuously with a=6, b=10 → done pulses every 5 cycles; each result is sum=0, cout=1; no idle cycle between operations.
6. WIDTH=8, a=200, b=100 → sum=44, cout=1; done arrives 9 cycles after the start edge; 8 ser_shift cycles.
